mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/llsc_link_reg.sv | 52 +++++
 rtl/mem_access_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type, memory-controller state encoding
// and a helper that extracts the word index from a byte address.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = WORD_W - 2;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  word_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } memctrl_state_t;

  function automatic word_idx_t word_idx(input word_t a);
    return a[WORD_W-1:2];
  endfunction

endpackage

// File: rtl/llsc_link_reg.sv
// Load-linked reservation: one valid bit plus the reserved word index.
// A coherence invalidate to the reserved word drops the reservation; if it
// lands on the same edge as a new LL to that word, the invalidate wins.
module llsc_link_reg
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      nRST,
  input  logic      set,
  input  word_idx_t set_idx,
  input  logic      clr,
  input  logic      snoop_inv,
  input  word_idx_t snoop_idx,
  input  word_idx_t cmp_idx,
  output word_idx_t link_addr,
  output logic      match,
  output logic      snoop_hit
);

  logic      link_valid_q, link_valid_d;
  word_idx_t link_addr_q, link_addr_d;
  logic      snoop_new;

  // Next reservation: set beats clear, but a same-edge invalidate beats set.
  always_comb begin
    snoop_hit    = snoop_inv && link_valid_q && (snoop_idx == link_addr_q);
    snoop_new    = snoop_inv && (snoop_idx == set_idx);
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    if (set) begin
      link_valid_d = !snoop_new;
      link_addr_d  = set_idx;
    end else if (clr || snoop_hit) begin
      link_valid_d = 1'b0;
    end
  end

  // Reservation storage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign link_addr = link_addr_q;
  assign match     = link_valid_q && (cmp_idx == link_addr_q);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache access controller with LL/SC support and sticky halt.
// A memory op is accepted in IDLE (stall raised combinationally), held in REQ
// until dhit, and retired with a one-cycle mem_done pulse in DONE. A failing
// SC never touches the cache and goes straight to DONE.
module mem_access_ctrl
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  exmem_valid,
  input  logic  MemRead_in,
  input  logic  MemWrite_in,
  input  logic  LL_in,
  input  logic  SC_in,
  input  logic  halt_in,
  input  word_t addr_in,
  input  word_t store_in,
  input  logic  dhit,
  input  word_t dmemload,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output word_t dmemstore,
  output logic  mem_stall,
  output logic  mem_done,
  output word_t load_data,
  output word_t sc_result,
  output logic  halted
);

  memctrl_state_t state_q, state_d;
  word_idx_t      addr_q, addr_d;
  word_t          store_q, store_d;
  word_t          load_q, load_d;
  logic           read_q, read_d;
  logic           write_q, write_d;
  logic           ll_q, ll_d;
  logic           sc_q, sc_d;
  logic           sc_res_q, sc_res_d;

  logic      accept, is_sc, sc_fail;
  logic      link_set, link_clr, link_match, snoop_hit;
  word_idx_t link_addr;
  logic      unused_addr_bits;

  assign unused_addr_bits = ^{addr_in[1:0], snoop_addr[1:0]};

  llsc_link_reg u_link (
    .CLK       (CLK),
    .nRST      (nRST),
    .set       (link_set),
    .set_idx   (addr_q),
    .clr       (link_clr),
    .snoop_inv (snoop_inv),
    .snoop_idx (word_idx(snoop_addr)),
    .cmp_idx   (word_idx(addr_in)),
    .link_addr (link_addr),
    .match     (link_match),
    .snoop_hit (snoop_hit)
  );

  // Next-state, capture and stall decode. Stall is gated by nRST so that it
  // reads low for the whole reset window even if a request is presented.
  always_comb begin
    accept    = nRST && exmem_valid && (MemRead_in || MemWrite_in);
    is_sc     = SC_in && MemWrite_in;
    sc_fail   = is_sc && !(link_match && !snoop_hit);
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    load_d    = load_q;
    read_d    = read_q;
    write_d   = write_q;
    ll_d      = ll_q;
    sc_d      = sc_q;
    sc_res_d  = sc_res_q;
    link_set  = 1'b0;
    link_clr  = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (exmem_valid && halt_in) begin
          state_d = HALTED;
        end else if (accept) begin
          mem_stall = 1'b1;
          addr_d    = word_idx(addr_in);
          store_d   = store_in;
          read_d    = MemRead_in;
          write_d   = MemWrite_in;
          ll_d      = LL_in && MemRead_in;
          sc_d      = is_sc;
          if (sc_fail) begin
            sc_res_d = 1'b0;
            state_d  = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dhit) begin
          if (read_q) load_d = dmemload;
          link_set = read_q && ll_q;
          link_clr = write_q && (sc_q || (link_addr == addr_q));
          if (sc_q) sc_res_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      HALTED:  mem_stall = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // All controller state; reset clears everything asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      load_q   <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      ll_q     <= 1'b0;
      sc_q     <= 1'b0;
      sc_res_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      load_q   <= load_d;
      read_q   <= read_d;
      write_q  <= write_d;
      ll_q     <= ll_d;
      sc_q     <= sc_d;
      sc_res_q <= sc_res_d;
    end
  end

  assign dmemREN   = (state_q == REQ) && read_q;
  assign dmemWEN   = (state_q == REQ) && write_q;
  assign dmemaddr  = {addr_q, 2'b00};
  assign dmemstore = store_q;
  assign mem_done  = (state_q == DONE);
  assign load_data = load_q;
  assign sc_result = {31'd0, sc_res_q};
  assign halted    = (state_q == HALTED);

endmodule
